// File: rtl/prf_free_list.sv
// prf_free_list: circular FIFO of free physical register tags.
//   Commit returns freed tags; rename allocates them.
//   Rename dequeues up to DEQ_WIDTH tags per cycle, all-or-nothing.
//   Commit enqueues up to ENQ_WIDTH tags per cycle; the request is always accepted.
//   Reset state: tags ARCH_REG_COUNT..PR_COUNT-1 are free, stored in order from entry 0.
//
// Optional feature: define PRF_FREE_LIST_BYPASS_EN to let same-cycle enqueued tags
//   satisfy dequeue ranks beyond the stored free count. Bypassed tags are never written.
//
// Ports:
//   CLK, nRST       clock, asynchronous active-low reset
//   deq_req_mask    ways requesting a new tag (any bit pattern)
//   deq_ready       combinational; 1 when every requested way is granted this cycle
//   deq_PR_by_way   combinational; tag per way, way k at bits [k*LOG_PR_COUNT +: LOG_PR_COUNT]
//   enq_valid_mask  ways returning a tag
//   enq_PR_by_way   returned tags, packed like deq_PR_by_way
//   free_count      registered count of stored free tags
//   overflow_err    sticky; set when the count would exceed PR_COUNT, cleared only by reset
module prf_free_list #(
  parameter int unsigned  PR_COUNT       = 128,
  parameter int unsigned  ARCH_REG_COUNT = 32,
  parameter int unsigned  DEQ_WIDTH      = 4,
  parameter int unsigned  ENQ_WIDTH      = 4,
  localparam int unsigned LOG_PR_COUNT   = $clog2(PR_COUNT)
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [DEQ_WIDTH-1:0]              deq_req_mask,
  output logic                              deq_ready,
  output logic [DEQ_WIDTH*LOG_PR_COUNT-1:0] deq_PR_by_way,
  input  logic [ENQ_WIDTH-1:0]              enq_valid_mask,
  input  logic [ENQ_WIDTH*LOG_PR_COUNT-1:0] enq_PR_by_way,
  output logic [LOG_PR_COUNT:0]             free_count,
  output logic                              overflow_err
);

  localparam int unsigned PTR_W     = LOG_PR_COUNT + 1;  // MSB is the wrap bit
  localparam int unsigned CNT_W     = LOG_PR_COUNT + 1;
  localparam int unsigned SUM_W     = CNT_W + 1;         // headroom for the overflow compare
  localparam int unsigned INIT_FREE = PR_COUNT - ARCH_REG_COUNT;

  logic [LOG_PR_COUNT-1:0] entry [PR_COUNT];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [PTR_W-1:0]        head_next;
  logic [PTR_W-1:0]        tail_next;

  logic [CNT_W-1:0]        deq_rank [DEQ_WIDTH];
  logic [CNT_W-1:0]        enq_rank [ENQ_WIDTH];
  logic [CNT_W-1:0]        n_req;
  logic [CNT_W-1:0]        n_enq;
  logic [CNT_W-1:0]        n_grant;
  logic [CNT_W-1:0]        n_byp;
  logic [SUM_W-1:0]        avail;
  logic [SUM_W-1:0]        count_next;

  logic [ENQ_WIDTH-1:0]    wr_en;
  logic [LOG_PR_COUNT-1:0] wr_idx [ENQ_WIDTH];

  // Rank of each way among the set bits below it, plus the popcounts.
  always_comb begin
    n_req = '0;
    for (int k = 0; k < int'(DEQ_WIDTH); k++) begin
      deq_rank[k] = n_req;
      if (deq_req_mask[k]) n_req = n_req + CNT_W'(1);
    end
    n_enq = '0;
    for (int k = 0; k < int'(ENQ_WIDTH); k++) begin
      enq_rank[k] = n_enq;
      if (enq_valid_mask[k]) n_enq = n_enq + CNT_W'(1);
    end
  end

`ifdef PRF_FREE_LIST_BYPASS_EN
  // Valid enqueue tags compacted into enqueue order, for same-cycle bypass.
  logic [LOG_PR_COUNT-1:0] enq_cmp [ENQ_WIDTH];

  always_comb begin
    for (int j = 0; j < int'(ENQ_WIDTH); j++) begin
      enq_cmp[j] = '0;
      for (int k = 0; k < int'(ENQ_WIDTH); k++) begin
        if (enq_valid_mask[k] && (enq_rank[k] == CNT_W'(j))) begin
          enq_cmp[j] = enq_PR_by_way[k*LOG_PR_COUNT +: LOG_PR_COUNT];
        end
      end
    end
  end
`endif

  // Dequeue grant and per-way tag selection.
  always_comb begin
    logic [LOG_PR_COUNT-1:0] rd_idx;
    logic [LOG_PR_COUNT-1:0] tag;
    deq_PR_by_way = '0;
    rd_idx        = '0;
    tag           = '0;
`ifdef PRF_FREE_LIST_BYPASS_EN
    avail = SUM_W'(free_count) + SUM_W'(n_enq);
`else
    avail = SUM_W'(free_count);
`endif
    deq_ready = (SUM_W'(n_req) <= avail);
    n_grant   = deq_ready ? n_req : '0;
    n_byp     = '0;
`ifdef PRF_FREE_LIST_BYPASS_EN
    // Ranks beyond the stored count are served by this cycle's enqueue ways.
    if (deq_ready && (n_req > free_count)) n_byp = n_req - free_count;
`endif
    for (int k = 0; k < int'(DEQ_WIDTH); k++) begin
      rd_idx = head[LOG_PR_COUNT-1:0] + LOG_PR_COUNT'(deq_rank[k]);
      tag    = entry[rd_idx];
`ifdef PRF_FREE_LIST_BYPASS_EN
      if (deq_rank[k] >= free_count) begin
        for (int j = 0; j < int'(ENQ_WIDTH); j++) begin
          if ((deq_rank[k] - free_count) == CNT_W'(j)) tag = enq_cmp[j];
        end
      end
`endif
      deq_PR_by_way[k*LOG_PR_COUNT +: LOG_PR_COUNT] = tag;
    end
  end

  // Enqueue placement, pointer and count updates.
  // Bypassed enqueue ways are the lowest ranks, so storage writes start after them.
  always_comb begin
    for (int k = 0; k < int'(ENQ_WIDTH); k++) begin
      wr_en[k]  = enq_valid_mask[k] && (enq_rank[k] >= n_byp);
      wr_idx[k] = tail[LOG_PR_COUNT-1:0] + LOG_PR_COUNT'(enq_rank[k] - n_byp);
    end
    head_next  = head + PTR_W'(n_grant - n_byp);
    tail_next  = tail + PTR_W'(n_enq - n_byp);
    count_next = SUM_W'(free_count) + SUM_W'(n_enq) - SUM_W'(n_grant);
  end

  // Pointers, count and sticky overflow flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head         <= '0;
      tail         <= PTR_W'(INIT_FREE);
      free_count   <= CNT_W'(INIT_FREE);
      overflow_err <= 1'b0;
    end else begin
      head       <= head_next;
      tail       <= tail_next;
      free_count <= CNT_W'(count_next);
      if (count_next > SUM_W'(PR_COUNT)) overflow_err <= 1'b1;
    end
  end

  // Tag storage; reset preloads the tags not mapped to architectural registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < PR_COUNT; i++) begin
        entry[i] <= (i < INIT_FREE) ? LOG_PR_COUNT'(i + ARCH_REG_COUNT) : '0;
      end
    end else begin
      for (int k = 0; k < int'(ENQ_WIDTH); k++) begin
        if (wr_en[k]) entry[wr_idx[k]] <= enq_PR_by_way[k*LOG_PR_COUNT +: LOG_PR_COUNT];
      end
    end
  end

endmodule

// File: tb/tb_prf_free_list.sv
`timescale 1ns/1ps
module tb_prf_free_list;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  deq_req_mask;
  logic        deq_ready;
  logic [27:0] deq_PR_by_way;
  logic [3:0]  enq_valid_mask;
  logic [27:0] enq_PR_by_way;
  logic [7:0]  free_count;
  logic        overflow_err;

  always #5 CLK = ~CLK;

  prf_free_list dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .deq_req_mask   (deq_req_mask),
    .deq_ready      (deq_ready),
    .deq_PR_by_way  (deq_PR_by_way),
    .enq_valid_mask (enq_valid_mask),
    .enq_PR_by_way  (enq_PR_by_way),
    .free_count     (free_count),
    .overflow_err   (overflow_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: free tags as an ordered queue (front = next to allocate).
  int model_q[$];
  bit model_err;
  bit ovf_mode;   // after an overflow the storage contents are not meaningful

  bit obs_ready;
  int obs_tag[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] tags4(input int t0, input int t1, input int t2, input int t3);
    return {7'(t3), 7'(t2), 7'(t1), 7'(t0)};
  endfunction

  task automatic model_reset();
    model_q.delete();
    for (int i = 32; i < 128; i++) model_q.push_back(i);
    model_err = 1'b0;
    ovf_mode  = 1'b0;
  endtask

  // Asserted asynchronously, released away from the clock edge.
  task automatic apply_reset();
    nRST           = 1'b0;
    deq_req_mask   = '0;
    enq_valid_mask = '0;
    enq_PR_by_way  = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #3 nRST = 1'b1;
    #1;
    check("rst_free_count", free_count, 96);
    check("rst_overflow", overflow_err, 0);
  endtask

  // One clock: drive, check combinational outputs, clock, check registered outputs.
  task automatic do_cycle(input logic [3:0] dm, input logic [3:0] em, input logic [27:0] et);
    int  n_req;
    int  n_enq;
    int  avail;
    int  e;
    bit  exp_ready;
    int  elist[$];
    deq_req_mask   = dm;
    enq_valid_mask = em;
    enq_PR_by_way  = et;
    #1;
    n_req = $countones(dm);
    n_enq = $countones(em);
    for (int k = 0; k < 4; k++) if (em[k]) elist.push_back(int'(et[k*7 +: 7]));
    avail = model_q.size();
`ifdef PRF_FREE_LIST_BYPASS_EN
    avail = avail + n_enq;
`endif
    exp_ready = (n_req <= avail);
    obs_ready = deq_ready;
    for (int k = 0; k < 4; k++) obs_tag[k] = int'(deq_PR_by_way[k*7 +: 7]);
    if (!ovf_mode) check("deq_ready", deq_ready, exp_ready);
    if (exp_ready) begin
      for (int k = 0; k < 4; k++) begin
        if (dm[k]) begin
          if (model_q.size() > 0) e = model_q.pop_front();
          else                    e = elist.pop_front();
          if (!ovf_mode) check($sformatf("deq_tag_w%0d", k), obs_tag[k], e);
        end
      end
    end
    foreach (elist[i]) model_q.push_back(elist[i]);
    if (model_q.size() > 128) begin
      model_err = 1'b1;
      ovf_mode  = 1'b1;
    end
    @(posedge CLK);
    #1;
    if (!ovf_mode) check("free_count", free_count, model_q.size());
    check("overflow_err", overflow_err, model_err);
  endtask

  initial begin
    logic [3:0]  dm;
    logic [3:0]  em;
    logic [27:0] et;

    // Full-width allocation right after reset.
    apply_reset();
    do_cycle(4'b0000, 4'b0000, '0);
    check("idle_ready", obs_ready, 1);
    do_cycle(4'b1111, 4'b0000, '0);
    check("t1_ready", obs_ready, 1);
    check("t1_w0", obs_tag[0], 32);
    check("t1_w1", obs_tag[1], 33);
    check("t1_w2", obs_tag[2], 34);
    check("t1_w3", obs_tag[3], 35);
    check("t1_fc", free_count, 92);

    // Sparse request mask is compacted.
    apply_reset();
    do_cycle(4'b1010, 4'b0000, '0);
    check("t2_w1", obs_tag[1], 32);
    check("t2_w3", obs_tag[3], 33);
    check("t2_fc", free_count, 94);

    // Drain to empty, then a request must be refused.
    apply_reset();
    repeat (24) do_cycle(4'b1111, 4'b0000, '0);
    check("drain_fc", free_count, 0);
    do_cycle(4'b0001, 4'b0000, '0);
    check("empty_ready", obs_ready, 0);
    check("empty_fc", free_count, 0);

    // Enqueue into empty list with a simultaneous request.
    do_cycle(4'b0001, 4'b0011, tags4(5, 9, 0, 0));
`ifdef PRF_FREE_LIST_BYPASS_EN
    check("byp_ready", obs_ready, 1);
    check("byp_w0", obs_tag[0], 5);
    check("byp_fc", free_count, 1);
    do_cycle(4'b0001, 4'b0000, '0);
    check("byp_next_w0", obs_tag[0], 9);
`else
    check("nobyp_ready", obs_ready, 0);
    check("nobyp_fc", free_count, 2);
    do_cycle(4'b0001, 4'b0000, '0);
    check("nobyp_next_ready", obs_ready, 1);
    check("nobyp_next_w0", obs_tag[0], 5);
`endif

    // Wrap: take all 96, return 100 across the index 127 -> 0 boundary.
    apply_reset();
    repeat (24) do_cycle(4'b1111, 4'b0000, '0);
    for (int c = 0; c < 25; c++) begin
      do_cycle(4'b0000, 4'b1111,
               tags4(((c*4+0)*37+3) % 128, ((c*4+1)*37+3) % 128,
                     ((c*4+2)*37+3) % 128, ((c*4+3)*37+3) % 128));
    end
    check("wrap_fc", free_count, 100);
    repeat (25) do_cycle(4'b1111, 4'b0000, '0);
    check("wrap_drained_fc", free_count, 0);

    // Overflow: 33 returns on top of 96 free tags.
    apply_reset();
    repeat (8) do_cycle(4'b0000, 4'b1111, tags4(1, 2, 3, 4));
    check("full_fc", free_count, 128);
    check("full_no_ovf", overflow_err, 0);
    do_cycle(4'b0000, 4'b0001, tags4(7, 0, 0, 0));
    check("ovf_set", overflow_err, 1);
    repeat (3) do_cycle(4'b0000, 4'b0000, '0);
    check("ovf_sticky", overflow_err, 1);
    apply_reset();

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 600; c++) begin
      dm = 4'($urandom);
      et = 28'($urandom);
      if (c < 150 && $urandom_range(0, 3) != 0) em = 4'b0000;
      else                                        em = 4'($urandom);
      if (model_q.size() + $countones(em) > 128) em = 4'b0000;
      if (c == 300) apply_reset();
      do_cycle(dm, em, et);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
